// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths, source ids and the zero register for the writeback arbiter
package regfile_wb_arbiter_pkg;
  localparam int AW_DEFAULT = 5;
  localparam int DW_DEFAULT = 32;
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;
  localparam logic [AW_DEFAULT-1:0] REG_ZERO = {AW_DEFAULT{1'b0}};
endpackage

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register file write port between ALU and load writebacks
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  output logic [AW-1:0] writeReg,
  output logic [DW-1:0] WriteData,
  output logic          RegWrite,
  input  logic [AW-1:0] reg1,
  input  logic [AW-1:0] reg2,
  output logic          byp1_hit,
  output logic          byp2_hit,
  output logic [DW-1:0] byp_data
);
  logic rr;
  logic grant;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_data;
  // grant the lone requester, or the one the pointer favours when both request
  always_comb begin
    alu_ready = !hold && alu_valid && (!mem_valid || rr == SRC_ALU);
    mem_ready = !hold && mem_valid && (!alu_valid || rr == SRC_MEM);
    grant     = alu_ready || mem_ready;
    g_addr    = alu_ready ? alu_addr : mem_addr;
    g_data    = alu_ready ? alu_data : mem_data;
    byp1_hit  = RegWrite && writeReg == reg1 && reg1 != '0;
    byp2_hit  = RegWrite && writeReg == reg2 && reg2 != '0;
    byp_data  = WriteData;
  end
  // write stage and pointer; zero-register grants are consumed but never enable the write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr        <= SRC_ALU;
      RegWrite  <= 1'b0;
      writeReg  <= '0;
      WriteData <= '0;
    end else if (!hold) begin
      RegWrite <= grant && g_addr != '0;
      if (grant) begin
        rr        <= alu_ready ? SRC_MEM : SRC_ALU;
        writeReg  <= g_addr;
        WriteData <= g_data;
      end
    end
  end
endmodule
